staggered_subtractor: RTL and testbench

STAGGERED_SUBTRACTOR -- requirements
Module: staggered_subtractor

---
 rtl/staggered_subtractor.sv | 151 +++++++++++++++
 tb/tb_staggered_subtractor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/staggered_subtractor.sv
// -----------------------------------------------------------------------------
// staggered_subtractor
//
// Computes diff = a - b - bin (modulo 2^WIDTH), 4 bits per clock.
// Each CALC cycle handles one 4-bit slice as a carry-lookahead add of
// a + ~b + carry. The carry register starts at ~bin, so borrow and carry
// are complements of each other throughout.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE. A
// result transfer returns the FSM to IDLE, so a new operand can never be
// accepted on the same edge as a result transfer.
//
// Ports:
//   clk       - sole clock, rising edge
//   rst       - synchronous, active-high reset
//   in_valid  - a/b/bin valid          in_ready  - ready for operands
//   a, b      - minuend / subtrahend   bin       - borrow-in
//   out_valid - result valid           out_ready - consumer accepts result
//   diff      - a - b - bin            bout      - borrow-out (a < b + bin)
//   ovf       - two's-complement overflow
//   state_dbg - current FSM state (IDLE=0, CALC=1, DONE=2)
// -----------------------------------------------------------------------------
module staggered_subtractor #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic [1:0]       state_dbg
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [KW-1:0]    k_q, k_d;
   logic             carry_q, carry_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   // slice datapath
   int               base;
   logic [3:0]       a_sl, nb_sl, p, g, c, sum;
   logic             c_out;

   always_comb begin
      base  = int'(k_q) * SLICE;
      a_sl  = a_q[base +: 4];
      nb_sl = ~b_q[base +: 4];
      p     = a_sl ^ nb_sl;
      g     = a_sl & nb_sl;
      // every carry is expanded directly from carry_q, no rippling
      c[0]  = carry_q;
      c[1]  = g[0] | (p[0] & carry_q);
      c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
      c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & carry_q);
      c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & carry_q);
      sum   = p ^ c;
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      k_d     = k_q;
      carry_d = carry_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               k_d     = '0;
               carry_d = ~bin;
               state_d = CALC;
            end
         end
         CALC: begin
            diff_d[base +: 4] = sum;
            carry_d           = c_out;
            k_d               = k_q + 1'b1;
            if (k_q == KW'(NSLICE - 1)) begin
               // flags are registered on the final slice so they are
               // already valid in the first DONE cycle
               bout_d  = ~c_out;
               ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (sum[3] != a_q[WIDTH-1]);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_staggered_subtractor.sv
// -----------------------------------------------------------------------------
// tb_staggered_subtractor
//
// Directed cases plus random operations against an integer-arithmetic
// reference model. Expected results are queued at acceptance and popped
// when out_valid rises.
// -----------------------------------------------------------------------------
module tb_staggered_subtractor;

   localparam int W      = 16;
   localparam int NSLICE = W / 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;
   logic [1:0]   state_dbg;

   int tests_run = 0;
   int tests_failed = 0;

   // {diff, bout, ovf}
   logic [W+1:0] exp_q[$];

   staggered_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .ovf(ovf),
      .state_dbg(state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // reference: plain integer arithmetic on the operand values
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
      int ux, uy, ud, sx, sy, sr;
      logic [W-1:0] d;
      logic bo, ov;
      ux = int'({16'd0, x});
      uy = int'({16'd0, y});
      ud = ux - uy - int'({31'd0, c});
      d  = ud[W-1:0];
      bo = (ux < uy + int'({31'd0, c}));
      sx = int'($signed(x));
      sy = int'($signed(y));
      sr = sx - sy - int'({31'd0, c});
      ov = (sr > 32767) || (sr < -32768);
      return {d, bo, ov};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one full operation; called #1 after an edge with the DUT in IDLE
   task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         input logic bin_i, input int hold);
      int           lat;
      logic [W+1:0] exp;
      logic [W-1:0] d_snap;
      logic         bo_snap, ov_snap;
      check("in_ready_idle", 32'(in_ready), 32'd1);
      a = a_i; b = b_i; bin = bin_i; in_valid = 1'b1;
      exp_q.push_back(model(a_i, b_i, bin_i));
      tick();                       // accepting edge counts as edge 1
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      lat = 1;
      while (!out_valid && lat < 50) begin
         if (in_ready) check("in_ready_busy", 32'(in_ready), 32'd0);
         tick();
         lat++;
      end
      check("latency", 32'(lat), 32'(NSLICE + 1));
      exp = exp_q.pop_front();
      check("diff", 32'(diff), 32'(exp[W+1:2]));
      check("bout", 32'(bout), 32'(exp[1]));
      check("ovf",  32'(ovf),  32'(exp[0]));
      d_snap = diff; bo_snap = bout; ov_snap = ovf;
      // hold the result back; in_valid stays high and must be ignored
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_ready", 32'(in_ready), 32'd0);
         check("hold_diff",  32'(diff), 32'(d_snap));
         check("hold_flags", 32'({bout, ovf}), 32'({bo_snap, ov_snap}));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("post_valid", 32'(out_valid), 32'd0);
      check("post_ready", 32'(in_ready), 32'd1);
      check("post_state", 32'(state_dbg), 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("rst_in_ready",  32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff",      32'(diff), 32'd0);
      check("rst_flags",     32'({bout, ovf}), 32'd0);
      check("rst_state",     32'(state_dbg), 32'd0);

      // directed cases
      run_op(16'h1234, 16'h0234, 1'b0, 0);
      check("dir1_diff", 32'(diff), 32'h1000);
      run_op(16'h0000, 16'h0001, 1'b0, 1);
      run_op(16'h8000, 16'h0001, 1'b0, 0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 2);
      run_op(16'h0005, 16'h0005, 1'b1, 0);
      run_op(16'h0005, 16'h0005, 1'b0, 10);
      run_op(16'h8000, 16'h0000, 1'b1, 0);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);

      // reset on the 2nd CALC edge discards the operation
      a = 16'hABCD; b = 16'h1234; bin = 1'b0; in_valid = 1'b1;
      tick();                       // accept
      in_valid = 1'b0;
      tick();                       // 1st CALC edge
      rst = 1'b1;
      tick();                       // 2nd CALC edge, reset wins
      rst = 1'b0;
      check("midrst_in_ready",  32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_diff",      32'(diff), 32'd0);
      check("midrst_flags",     32'({bout, ovf}), 32'd0);
      run_op(16'h4321, 16'h1111, 1'b1, 0);

      // reset while in DONE
      a = 16'h0001; b = 16'h0002; bin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < NSLICE; i++) tick();
      check("done_reached", 32'(out_valid), 32'd1);
      out_ready = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b0;
      check("donerst_ready", 32'(in_ready), 32'd1);
      check("donerst_diff",  32'(diff), 32'd0);

      // random operations
      for (int n = 0; n < 60; n++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end
      // boundary-heavy random operands
      for (int n = 0; n < 20; n++) begin
         logic [W-1:0] ra, rb;
         ra = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
         rb = ($urandom_range(0, 1) == 1) ? 16'hFFFF : W'($urandom_range(0, 2));
         run_op(ra, rb, 1'($urandom), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
